// File: rtl/bcd_disp_ctrl.sv
// bcd_disp_ctrl: sequences a shared binary-to-BCD converter and scans the packed-BCD
// result onto a common-anode multiplexed 7-segment display.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   value_i         binary sample, qualified by the 1-cycle strobe value_vld_i
//   conv_en_o       1-cycle converter start strobe
//   conv_data_o     converter operand, held from ISSUE through LATCH
//   conv_data_i     packed BCD result from the converter (digit 0 in [3:0])
//   conv_rdy_i      converter done level
//   busy_o          a conversion is in flight (ISSUE/WAIT/LATCH)
//   err_o           sticky conversion-timeout flag, cleared by rst only
//   an_o            one-hot active-low digit enables
//   seg_o           active-low segments {g,f,e,d,c,b,a}
//
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the most-significant
// nonzero digit (digit 0 is always shown).
module bcd_disp_ctrl #(
    parameter int unsigned DATA_IN_WIDTH = 16,
    parameter int unsigned DIGITS        = 5,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_IN_WIDTH-1:0] value_i,
    input  logic                     value_vld_i,
    output logic                     conv_en_o,
    output logic [DATA_IN_WIDTH-1:0] conv_data_o,
    input  logic [4*DIGITS-1:0]      conv_data_i,
    input  logic                     conv_rdy_i,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [DIGITS-1:0]        an_o,
    output logic [6:0]               seg_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_LATCH
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic                     r_pend, w_pend_nxt;
    logic [DATA_IN_WIDTH-1:0] r_pend_data, w_pend_data_nxt;
    logic [BCD_W-1:0]         r_digits, w_digits_nxt;
    logic [DATA_IN_WIDTH-1:0] w_op_nxt;
    logic                     w_err_nxt;
    logic                     w_en_nxt;
    logic                     w_busy_nxt;

    logic [DIV_W-1:0]         r_div, w_div_nxt;
    logic [IDX_W-1:0]         r_idx, w_idx_nxt;
    logic [3:0]               w_nib;
    logic                     w_blank;
    logic [DIGITS-1:0]        w_an_nxt;
    logic [6:0]               w_seg_nxt;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and sequencing datapath.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pend_nxt      = r_pend;
        w_pend_data_nxt = r_pend_data;
        w_digits_nxt    = r_digits;
        w_op_nxt        = conv_data_o;
        w_err_nxt       = err_o;

        // Any strobe not launched directly from IDLE becomes the pending sample (latest wins).
        if (value_vld_i) begin
            w_pend_nxt      = 1'b1;
            w_pend_data_nxt = value_i;
        end

        case (r_state)
            ST_BOOT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (value_vld_i) begin
                    w_op_nxt    = value_i;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = ST_ISSUE;
                end else if (r_pend) begin
                    w_op_nxt    = r_pend_data;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // rdy is still the stale level during the first WAIT cycle.
                if ((r_cnt != '0) && conv_rdy_i) begin
                    w_state_nxt = ST_LATCH;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LATCH: begin
                w_digits_nxt = conv_data_i;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        w_en_nxt   = (w_state_nxt == ST_ISSUE);
        w_busy_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT) ||
                     (w_state_nxt == ST_LATCH);
    end

    // Sequencing registers and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_digits    <= '0;
            conv_en_o   <= 1'b0;
            conv_data_o <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_data <= w_pend_data_nxt;
            r_digits    <= w_digits_nxt;
            conv_en_o   <= w_en_nxt;
            conv_data_o <= w_op_nxt;
            busy_o      <= w_busy_nxt;
            err_o       <= w_err_nxt;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_upper_zero;

    // Bit i set when digit i and every digit above it are zero.
    always_comb begin : lzb_scan
        logic acc;
        acc          = 1'b1;
        w_upper_zero = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            acc             = acc & (r_digits[4*i +: 4] == 4'd0);
            w_upper_zero[i] = acc;
        end
    end
`endif

    // Refresh divider, digit index and segment/anode selection.
    always_comb begin
        w_div_nxt = r_div + 1'b1;
        w_idx_nxt = r_idx;
        if (r_div == DIV_LAST) begin
            w_div_nxt = '0;
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        w_nib   = 4'd0;
        w_blank = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib = r_digits[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = (i != 0) && w_upper_zero[i];
`endif
            end
        end

        w_seg_nxt = w_blank ? 7'h7F : seg_decode(w_nib);
        w_an_nxt  = ~(DIGITS'(1) << r_idx);
    end

    // Scan registers; anode and segments update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
            an_o  <= '1;
            seg_o <= 7'h7F;
        end else begin
            r_div <= w_div_nxt;
            r_idx <= w_idx_nxt;
            an_o  <= w_an_nxt;
            seg_o <= w_seg_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_disp_ctrl.sv
// Self-checking bench for bcd_disp_ctrl with a behavioural converter stub and an
// arithmetic reference for the expected BCD digits and segment patterns.
module tb_bcd_disp_ctrl;

    localparam int unsigned DW  = 16;
    localparam int unsigned DG  = 5;
    localparam int unsigned RD  = 3;
    localparam int unsigned TO  = 40;
    localparam int unsigned LAT = 12;
    localparam int unsigned QUIET_BUDGET = 4 * TO + 50;
    localparam logic [4*DG-1:0] CORRUPT = 20'h0F0C3;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     value_i;
    logic              value_vld_i;
    logic              conv_en_o;
    logic [DW-1:0]     conv_data_o;
    logic [4*DG-1:0]   conv_data_i = 20'h98765;
    logic              conv_rdy_i  = 1'b1;
    logic              busy_o;
    logic              err_o;
    logic [DG-1:0]     an_o;
    logic [6:0]        seg_o;

    int total = 0;
    int bad   = 0;

    bcd_disp_ctrl #(
        .DATA_IN_WIDTH(DW),
        .DIGITS       (DG),
        .REFRESH_DIV  (RD),
        .TIMEOUT      (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_i    (value_i),
        .value_vld_i(value_vld_i),
        .conv_en_o  (conv_en_o),
        .conv_data_o(conv_data_o),
        .conv_data_i(conv_data_i),
        .conv_rdy_i (conv_rdy_i),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .an_o       (an_o),
        .seg_o      (seg_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*DG-1:0] to_bcd(input int unsigned v);
        logic [4*DG-1:0] w;
        int unsigned p;
        w = '0;
        p = 1;
        for (int i = 0; i < int'(DG); i++) begin
            w[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return w;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [4*DG-1:0] w, input int i);
        logic [3:0] nib;
        nib = w[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (w >> (4*i)) == '0) return 7'h7F;
`endif
        case (nib)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Converter stub: keeps the stale rdy one more cycle after accepting a start.
    logic          stub_dead    = 1'b0;
    logic          stub_corrupt = 1'b0;
    logic          cv_busy      = 1'b0;
    int            cv_cnt       = 0;
    logic [DW-1:0] cv_op        = '0;

    always @(posedge clk) begin
        if (conv_en_o) begin
            cv_busy <= 1'b1;
            cv_cnt  <= int'(LAT);
            cv_op   <= conv_data_o;
        end else if (cv_busy) begin
            conv_rdy_i <= 1'b0;
            if (cv_cnt == 0) begin
                cv_busy <= 1'b0;
                if (!stub_dead) begin
                    conv_rdy_i  <= 1'b1;
                    conv_data_i <= stub_corrupt ? CORRUPT : to_bcd(int'(cv_op));
                end
            end else begin
                cv_cnt <= cv_cnt - 1;
            end
        end
    end

    // Launch monitor: records operands, checks pulse width and operand stability.
    logic [DW-1:0] q_ops[$];
    logic [DW-1:0] cur_op  = '0;
    logic          prev_en = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (conv_en_o) begin
                check("en_one_cycle", 32'(prev_en), 32'd0);
                q_ops.push_back(conv_data_o);
                cur_op = conv_data_o;
            end else if (busy_o) begin
                check("op_stable", 32'(conv_data_o), 32'(cur_op));
            end
        end
        prev_en = conv_en_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] v);
        value_i     = v;
        value_vld_i = 1'b1;
        step();
        value_vld_i = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int q;
        int n;
        q = 0;
        n = 0;
        while (q < 4 && n < int'(QUIET_BUDGET)) begin
            step();
            n++;
            q = busy_o ? 0 : q + 1;
        end
        check({tag, "_quiet"}, 32'(q >= 4), 32'd1);
    endtask

    task automatic check_display(input logic [4*DG-1:0] w, input string tag);
        logic [DG-1:0] tgt;
        int n;
        for (int i = 0; i < int'(DG); i++) begin
            tgt = ~(DG'(1) << i);
            n = 0;
            while (an_o !== tgt && n < int'(2 * DG * RD + 4)) begin
                step();
                n++;
            end
            check($sformatf("%s_an%0d", tag, i), 32'(an_o), 32'(tgt));
            check($sformatf("%s_seg%0d", tag, i), 32'(seg_o), 32'(exp_seg(w, i)));
        end
    endtask

    task automatic check_scan();
        logic [DG-1:0] t0;
        logic [DG-1:0] prev;
        int n;
        t0 = ~DG'(1);
        n = 0;
        while (an_o === t0 && n < int'(2 * DG * RD)) begin step(); n++; end
        while (an_o !== t0 && n < int'(4 * DG * RD)) begin step(); n++; end
        check("scan_sync", 32'(an_o), 32'(t0));
        prev = t0;
        for (int k = 1; k <= int'(2 * DG); k++) begin
            repeat (RD - 1) step();
            check($sformatf("scan_hold%0d", k), 32'(an_o), 32'(prev));
            step();
            prev = ~(DG'(1) << (k % int'(DG)));
            check($sformatf("scan_step%0d", k), 32'(an_o), 32'(prev));
        end
    endtask

    task automatic check_ops(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input int n);
        check({tag, "_nconv"}, 32'(q_ops.size()), 32'(n));
        if (q_ops.size() >= 1) check({tag, "_op0"}, 32'(q_ops[0]), 32'(a));
        if (n == 2 && q_ops.size() >= 2) check({tag, "_op1"}, 32'(q_ops[1]), 32'(b));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},   32'(conv_en_o),   32'd0);
        check({tag, "_data"}, 32'(conv_data_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o),      32'd0);
        check({tag, "_err"},  32'(err_o),       32'd0);
        check({tag, "_an"},   32'(an_o),        32'(DG'('1)));
        check({tag, "_seg"},  32'(seg_o),       32'h7F);
    endtask

    initial begin
        int k;
        logic [DW-1:0] v0;
        logic [DW-1:0] v;
        logic [DW-1:0] last;
        int nx;

        rst         = 1'b1;
        value_i     = '0;
        value_vld_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // Boot guard: a strobe during BOOT is held until the guard expires.
        q_ops.delete();
        rst         = 1'b0;
        value_i     = DW'(1234);
        value_vld_i = 1'b1;
        k = 0;
        while (k < int'(TO + 10) && !conv_en_o) begin
            step();
            k++;
            if (k == 1) value_vld_i = 1'b0;
        end
        check("boot_guard", 32'(k), 32'(TO + 1));
        check("boot_op", 32'(conv_data_o), 32'd1234);
        wait_quiet("t1");
        check_ops("t1", DW'(1234), '0, 1);
        check_display(to_bcd(1234), "t2");

        // Full-scale value and scan order.
        q_ops.delete();
        strobe(DW'(65535));
        wait_quiet("t3");
        check_ops("t3", DW'(65535), '0, 1);
        check_display(to_bcd(65535), "t3");
        check_scan();

        // Back-to-back strobes during WAIT: latest pending wins.
        q_ops.delete();
        strobe(DW'(100));
        repeat (3) step();
        strobe(DW'(200));
        strobe(DW'(300));
        wait_quiet("t4");
        check_ops("t4", DW'(100), DW'(300), 2);
        check_display(to_bcd(300), "t4");

        // Randomized samples with optional extra strobes while busy.
        for (int r = 0; r < 8; r++) begin
            q_ops.delete();
            v0 = DW'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            last = v0;
            strobe(v0);
            nx = int'($urandom_range(0, 3));
            if (nx > 0) begin
                repeat ($urandom_range(1, LAT - 4)) step();
                for (int j = 0; j < nx; j++) begin
                    v = DW'($urandom_range(0, 65535) >> $urandom_range(0, 15));
                    last = v;
                    strobe(v);
                end
            end
            wait_quiet($sformatf("rnd%0d", r));
            check_ops($sformatf("rnd%0d", r), v0, last, (nx > 0) ? 2 : 1);
            check_display(to_bcd(int'(last)), $sformatf("rnd%0d", r));
        end

        // Non-decimal nibbles go dark.
        q_ops.delete();
        stub_corrupt = 1'b1;
        strobe(DW'(1));
        wait_quiet("bad");
        stub_corrupt = 1'b0;
        check_display(CORRUPT, "bad");

        q_ops.delete();
        strobe(DW'(4321));
        wait_quiet("pre5");
        check_display(to_bcd(4321), "pre5");

        // Converter never answers: timeout, sticky error, digits retained.
        stub_dead = 1'b1;
        strobe(DW'(777));
        k = 0;
        while (!err_o && k < int'(TO + 20)) begin
            step();
            k++;
        end
        check("t5_err_cycle", 32'(k), 32'(TO + 1));
        check("t5_err", 32'(err_o), 32'd1);
        check("t5_busy", 32'(busy_o), 32'd0);
        wait_quiet("t5");
        check_display(to_bcd(4321), "t5");
        stub_dead = 1'b0;
        q_ops.delete();
        strobe(DW'(555));
        wait_quiet("t5b");
        check_ops("t5b", DW'(555), '0, 1);
        check_display(to_bcd(555), "t5b");
        check("t5_sticky", 32'(err_o), 32'd1);

        // Reset during WAIT: immediate clear, in-flight result never latched.
        q_ops.delete();
        strobe(DW'(888));
        repeat (4) step();
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6");
        step();
        step();
        rst = 1'b0;
        repeat (TO + LAT + 20) step();
        check("t6_nconv", 32'(q_ops.size()), 32'd1);
        check_display(to_bcd(0), "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
